// File: rtl/rom_d_arbiter.sv
// Two-port arbiter in front of the asynchronous-read instruction ROM.
// Port 0 (IF stage) has fixed priority; port 1 is forced through after STARVE_LIMIT denied cycles.
`timescale 1ns/1ps
module rom_d_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_spo,
  output logic [3:0]    busy_cnt
);
  // Handshake: mX_req/mX_addr stay stable until mX_gnt is seen high in the same
  // cycle; the read completes on that edge and mX_rvalid pulses for one cycle after it.

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]    r_wait_cnt;
  logic [AW-1:0] r_last_a;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  logic          w_starved;
  logic          w_m0_win;
  logic          w_m1_win;
  logic [AW-1:0] w_rom_a;

  // Grants depend only on requests and the wait counter, never on rom_spo.
  assign w_starved = m1_req && (r_wait_cnt == LIMIT);
  assign w_m1_win  = w_starved || (m1_req && !m0_req);
  assign w_m0_win  = m0_req && !w_starved;

  always_comb begin
    w_rom_a = r_last_a;
    if (rst)           w_rom_a = '0;
    else if (w_m1_win) w_rom_a = m1_addr;
    else if (w_m0_win) w_rom_a = m0_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_last_a    <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_m0_win;
      r_m1_rvalid <= w_m1_win;
      if (w_m0_win) r_m0_rdata <= rom_spo;
      if (w_m1_win) r_m1_rdata <= rom_spo;
      if (w_m0_win || w_m1_win) r_last_a <= w_rom_a;
      if (w_m1_win || !m1_req)      r_wait_cnt <= '0;
      else if (r_wait_cnt != LIMIT) r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign m0_gnt    = w_m0_win;
  assign m1_gnt    = w_m1_win;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign rom_a     = w_rom_a;
  assign busy_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_rom_d_arbiter.sv
// Bench for rom_d_arbiter: directed scenarios plus random traffic, checked by a
// reference model feeding per-port expected-data queues drained by a monitor.
`timescale 1ns/1ps
module tb_rom_d_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_spo;
  logic [3:0]    busy_cnt;

  assign rom_spo = 32'hA500_0000 | {{(DW-AW){1'b0}}, rom_a};

  rom_d_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rom_a(rom_a), .rom_spo(rom_spo), .busy_cnt(busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] last_d0 = '0, last_d1 = '0;
  int            m_cnt = 0;          // consecutive cycles port 1 asked and lost
  logic [AW-1:0] m_last_a = '0;
  int            m_win = -1;         // -1 none, 0 or 1 winning port this cycle
  logic [AW-1:0] m_win_addr = '0;
  logic          m_m1_req = 1'b0;

  function automatic int model_win(input logic r0, input logic r1, input int denied);
    if (r1 && denied >= LIMIT) return 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hA500_0000 | {{(DW-AW){1'b0}}, a};
  endfunction

  // Commit the decision made mid-cycle at each clock edge; reset discards everything.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      last_d0  = '0;
      last_d1  = '0;
      m_cnt    = 0;
      m_last_a = '0;
    end else begin
      if (m_win == 0) begin
        exp_q0.push_back(rom_word(m_win_addr));
        last_d0  = rom_word(m_win_addr);
        m_last_a = m_win_addr;
      end else if (m_win == 1) begin
        exp_q1.push_back(rom_word(m_win_addr));
        last_d1  = rom_word(m_win_addr);
        m_last_a = m_win_addr;
      end
      if (m_m1_req && m_win != 1) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else                        m_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] popped;
  logic [AW-1:0] exp_a;
  always @(negedge clk) begin
    m_win      = model_win(m0_req, m1_req, m_cnt);
    m_m1_req   = m1_req;
    m_win_addr = (m_win == 1) ? m1_addr : m0_addr;
    check("m0_gnt", m0_gnt, m_win == 0);
    check("m1_gnt", m1_gnt, m_win == 1);
    check("busy_cnt", busy_cnt, m_cnt);
    if (rst)            exp_a = '0;
    else if (m_win < 0) exp_a = m_last_a;
    else                exp_a = m_win_addr;
    check("rom_a", rom_a, exp_a);
    if (m0_rvalid) begin
      if (exp_q0.size() == 0) check("m0_rvalid_unexpected", m0_rvalid, 0);
      else begin popped = exp_q0.pop_front(); check("m0_rdata", m0_rdata, popped); end
    end else check("m0_rdata_hold", m0_rdata, last_d0);
    if (m1_rvalid) begin
      if (exp_q1.size() == 0) check("m1_rvalid_unexpected", m1_rvalid, 0);
      else begin popped = exp_q1.pop_front(); check("m1_rdata", m1_rdata, popped); end
    end else check("m1_rdata_hold", m1_rdata, last_d1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r0, input logic [AW-1:0] a0,
                       input logic r1, input logic [AW-1:0] a1);
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [AW-1:0] p1a [3];
  logic g0, g1;

  // ---------------- stimulus ----------------
  initial begin
    p1a[0] = 10'h3FF; p1a[1] = 10'h000; p1a[2] = 10'h155;
    drive(1'b0, '0, 1'b0, '0);

    // Reset held with random requests
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
    end
    at_neg();
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_busy", busy_cnt, 0);

    // Release reset, single port 0 read
    step();
    rst = 1'b0;
    drive(1'b1, 10'h00A, 1'b0, '0);
    at_neg();
    check("single_m0_gnt", m0_gnt, 1);
    step();
    drive(1'b0, '0, 1'b0, '0);
    at_neg();
    check("single_m0_rvalid", m0_rvalid, 1);
    check("single_m0_rdata", m0_rdata, 32'hA500_000A);
    check("single_m1_rvalid", m1_rvalid, 0);

    // Contention: both ports held for 10 cycles
    step();
    drive(1'b1, 10'h001, 1'b1, 10'h002);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      check("cont_m1_gnt", m1_gnt, (i % 5) == 4);
      check("cont_busy", busy_cnt, i % 5);
      check("cont_m1_rvalid", m1_rvalid, i == 5);
      if (i == 5) check("cont_m1_rdata", m1_rdata, 32'hA500_0002);
      step();
    end

    // Port 1 alone, back to back
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, '0, 1'b1, p1a[i]);
      else       drive(1'b0, '0, 1'b0, '0);
      at_neg();
      check("p1_gnt", m1_gnt, i < 3);
      if (i > 0) begin
        check("p1_rvalid", m1_rvalid, 1);
        check("p1_rdata", m1_rdata, rom_word(p1a[i-1]));
      end
      step();
    end
    at_neg();
    check("p1_rvalid_end", m1_rvalid, 0);

    // Idle address hold
    step();
    drive(1'b1, 10'h123, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("idle_rom_a", rom_a, 10'h123);
      check("idle_m0_rdata", m0_rdata, 32'hA500_0123);
      step();
    end

    // Reset pulse while a port 1 response is outstanding
    drive(1'b1, 10'h010, 1'b1, 10'h055);
    for (int i = 0; i < 2; i++) step();
    drive(1'b0, '0, 1'b1, 10'h055);
    at_neg();
    check("rr_m1_gnt", m1_gnt, 1);
    step();
    drive(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    at_neg();
    check("rr_m1_rvalid", m1_rvalid, 0);
    check("rr_m1_rdata", m1_rdata, 0);
    check("rr_busy", busy_cnt, 0);
    step();

    // Random traffic obeying the hold-until-granted rule
    for (int i = 0; i < 400; i++) begin
      at_neg();
      g0 = m0_gnt;
      g1 = m1_gnt;
      step();
      if (!m0_req || g0) begin
        m0_req  = ($urandom_range(0, 9) < 8);
        m0_addr = AW'($urandom);
      end
      if (!m1_req || g1) begin
        m1_req  = ($urandom_range(0, 9) < 5);
        m1_addr = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom);
      end
    end
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step();
    at_neg();
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_d_arbiter.md
# rom_d_arbiter

Shares the single asynchronous-read instruction ROM (`ROM_D`: 10-bit word address `a`, 32-bit data `spo`) between two requesters. Port 0 is the pipeline IF stage; port 1 is the secondary reader (debug/display). Arbitration is fixed priority to port 0, with a starvation guard that forces a port 1 grant after a bounded wait. Read data is registered and returned one cycle after the grant.

## Interface
- `AW`, 10: ROM word-address width.
- `DW`, 32: ROM data width.
- `STARVE_LIMIT`, 4: maximum number of consecutive denied cycles for port 1 before it is forced to win (range 1..15).

- `clk`  in  1  system clock; all state is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  port 0 read request; held until granted.
- `m0_addr`  in  AW  port 0 word address.
- `m0_gnt`  out  1  combinational; port 0 wins this cycle.
- `m0_rvalid`  out  1  registered; `m0_rdata` is valid this cycle.
- `m0_rdata`  out  DW  registered read data for port 0.
- `m1_req`, `m1_addr`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: identical to the port 0 signals, for port 1.
- `rom_a`  out  AW  address to `ROM_D.a`.
- `rom_spo`  in  DW  data from `ROM_D.spo` (combinational function of `rom_a`).
- `busy_cnt`  out  4  registered; current port 1 wait count (debug).

## Operation
- **At most one grant per cycle.** Winner selection:
  - `m1_req && wait_cnt == STARVE_LIMIT` → port 1;
  - else `m0_req` → port 0;
  - else `m1_req` → port 1;
  - else no grant.
- **Grant signals.** `mX_gnt` is a combinational function of `req` and `wait_cnt` only. No combinational path from `rom_spo` to a grant.
- **ROM address.** `rom_a` is the winner's address. With no grant, `rom_a` is `last_a`, a register updated with the winner's address on every grant.
- **Response.** On a grant edge, `rom_spo` is captured into the winner's `rdata` register and that port's `rvalid` is set for exactly one cycle. The loser's `rvalid` is 0.
- **Idle data.** `rdata` holds its value when `rvalid` is 0.
- **wait_cnt** (4 bits, output as `busy_cnt`):
  - cleared when `m1_gnt` is 1 or `m1_req` is 0;
  - otherwise incremented, saturating at `STARVE_LIMIT`.
- **Requester rules.**
  - A requester whose `gnt` is 0 keeps `req` and `addr` stable; the arbiter does not latch ungranted requests.
  - A requester may issue back-to-back requests; a grant every cycle is legal.
- **Back-to-back requests on port 0 with `m1_req` held.** Port 0 is granted `STARVE_LIMIT` times, port 1 once, and the pattern repeats. Port 1 bandwidth is therefore at least 1/(`STARVE_LIMIT`+1).

## Timing
- **Reset values** (asynchronous, while `rst` is 1): `m0_rvalid`, `m1_rvalid` = 0; `m0_rdata`, `m1_rdata` = 0; `last_a` = 0; `wait_cnt` = 0.
  - During reset, `rom_a` = 0 and the grants follow the combinational rule (`wait_cnt` = 0).
  - Grant edges while `rst` is asserted have no effect.
- **Latency.** Grant in cycle N → `rvalid` and `rdata` in cycle N+1. Throughput is one read per cycle overall.
- **Reset mid-operation.** If `rst` rises in cycle N+1 of an outstanding read, that read's `rvalid` is forced to 0 and the response is dropped.
- **Simultaneous requests, same address.** Only the winner receives data; the loser re-requests.
- **`wait_cnt` at the limit with `m0_req` = 1.** Port 1 wins. `wait_cnt` is 0 in the next cycle.
- **`m1_req` dropped before its grant.** `wait_cnt` returns to 0; nothing is remembered.
- **Address wrap-around.** `addr` = 10'h3FF is a normal read; there is no address arithmetic.

## Test plan
The bench uses a ROM model with `rom_spo` = 32'hA500_0000 | `rom_a`. `STARVE_LIMIT` = 4.
- **Reset.** Hold `rst` with random requests → all `rvalid` and `rdata` = 0, `busy_cnt` = 0. Release `rst` → first grant on the next edge.
- **Single port 0 read.** `m0_req` = 1 with `m0_addr` = 10'h00A for one cycle → `m0_gnt` = 1 in that cycle. Next cycle: `m0_rvalid` = 1, `m0_rdata` = 32'hA500_000A, `m1_rvalid` = 0.
- **Contention.** Both requesting, `m0_addr` = 1, `m1_addr` = 2, held 10 cycles → grant sequence 0,0,0,0,1,0,0,0,0,1. `busy_cnt` runs 0,1,2,3,4,0,…. Port 1 receives 32'hA500_0002.
- **Port 1 alone.** Back-to-back `m1_addr` 3FF, 000, 155 → three consecutive `m1_rvalid` cycles with data A500_03FF, A500_0000, A500_0155.
- **Idle address.** Grant port 0 at address 10'h123, then go idle → `rom_a` = 10'h123 while idle and `m0_rdata` stays A500_0123.
- **Reset mid-read.** Grant port 1, then pulse `rst` asynchronously before the next edge → no `m1_rvalid` pulse and `busy_cnt` = 0.
